// File: rtl/connect6_pkg.sv
// ============================================================================
// Module      : connect6_pkg
// Description : Shared cell encoding, reject codes, FSM states and the cell
//               index helper for the Connect6 board move engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package connect6_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_BLACK = 2'b01;
  localparam logic [1:0] CELL_WHITE = 2'b10;

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_COUNT      = 3'd1,
    ERR_BOUNDS     = 3'd2,
    ERR_OCCUPIED   = 3'd3,
    ERR_DUPLICATE  = 3'd4,
    ERR_EMPTY_HIST = 3'd5
  } err_code_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_COMMIT = 3'd2,
    ST_NOTIFY = 3'd3,
    ST_REJECT = 3'd4,
    ST_UNDO   = 3'd5
  } state_e;

  function automatic int cell_idx(input int row, input int col, input int n);
    return row * n + col;
  endfunction

endpackage

`default_nettype wire

// File: rtl/board_history_stack.sv
// ============================================================================
// Module      : board_history_stack
// Description : Circular undo stack of committed move packets; a push when
//               full overwrites the oldest entry. Built only with
//               BOARD_HISTORY_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef BOARD_HISTORY_EN
module board_history_stack #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int FW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_h,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] top_data,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [PW-1:0]    top_ptr;
  logic [PW-1:0]    next_ptr;

  assign top_ptr  = (wr_ptr_q == '0) ? PW'(DEPTH - 1) : wr_ptr_q - PW'(1);
  assign next_ptr = (int'(wr_ptr_q) == DEPTH - 1) ? '0 : wr_ptr_q + PW'(1);
  assign top_data = mem_q[top_ptr];
  assign empty    = (fill_q == '0);
  assign full     = (int'(fill_q) == DEPTH);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    if (clear) begin
      wr_ptr_d = '0;
      fill_d   = '0;
    end else if (push) begin
      wr_ptr_d = next_ptr;
      fill_d   = full ? fill_q : fill_q + FW'(1);
    end else if (pop && !empty) begin
      wr_ptr_d = top_ptr;
      fill_d   = fill_q - FW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset_h) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Storage is never reset: the fill count alone defines which entries are live.
  always_ff @(posedge clock) begin
    if (push && !clear) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule
`endif

`default_nettype wire

// File: rtl/board_move_engine.sv
// ============================================================================
// Module      : board_move_engine
// Description : Connect6 move applier. Validates 1..MAX_STONES stone packets
//               against the board register, commits them atomically and
//               pulses analyze. Define BOARD_HISTORY_EN for the undo stack.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module board_move_engine
  import connect6_pkg::*;
#(
  parameter  int BOARD_N    = 19,
  parameter  int MAX_STONES = 2,
  parameter  int HIST_DEPTH = 16,
  localparam int CW         = $clog2(BOARD_N),
  localparam int BW         = 2 * BOARD_N * BOARD_N,
  localparam int SW         = $clog2(MAX_STONES + 1)
) (
  input  logic                     clock,
  input  logic                     reset_h,
  input  logic                     clear,
  input  logic                     mv_valid,
  output logic                     mv_ready,
  input  logic [SW-1:0]            mv_count,
  input  logic                     mv_colour,
  input  logic [MAX_STONES*CW-1:0] mv_row,
  input  logic [MAX_STONES*CW-1:0] mv_col,
  output logic [BW-1:0]            board_out,
  output logic                     analyze,
  output logic                     mv_err,
  output logic [2:0]               err_code,
  output logic [15:0]              move_cnt
`ifdef BOARD_HISTORY_EN
  ,
  input  logic                     undo
`endif
);

  state_e                    state_q, state_d;
  logic [SW-1:0]             cnt_q, cnt_d;
  logic                      colour_q, colour_d;
  logic [MAX_STONES*CW-1:0]  row_q, row_d;
  logic [MAX_STONES*CW-1:0]  col_q, col_d;
  logic [SW-1:0]             k_q, k_d;
  logic [BW-1:0]             board_q, board_d;
  err_code_e                 err_q, err_d;
  logic [15:0]               move_cnt_q, move_cnt_d;
  logic                      analyze_q, analyze_d;
  logic                      mv_err_q, mv_err_d;
  logic                      mv_ready_q, mv_ready_d;

  logic [CW-1:0] cur_row, cur_col;
  logic          cur_in_bounds;
  int            cur_idx;
  logic [1:0]    cur_cell;
  logic          cur_dup;

  assign cur_row       = row_q[k_q*CW +: CW];
  assign cur_col       = col_q[k_q*CW +: CW];
  assign cur_in_bounds = (int'(cur_row) < BOARD_N) && (int'(cur_col) < BOARD_N);
  assign cur_idx       = cell_idx(int'(cur_row), int'(cur_col), BOARD_N);

  always_comb begin
    cur_cell = CELL_EMPTY;
    if (cur_in_bounds) begin
      cur_cell = board_q[2*cur_idx +: 2];
    end
  end

  always_comb begin
    cur_dup = 1'b0;
    for (int j = 0; j < MAX_STONES; j++) begin
      if (j < int'(k_q) && row_q[j*CW +: CW] == cur_row && col_q[j*CW +: CW] == cur_col) begin
        cur_dup = 1'b1;
      end
    end
  end

`ifdef BOARD_HISTORY_EN
  localparam int HW = SW + 1 + 2 * MAX_STONES * CW;

  logic                     hist_push, hist_pop, hist_clear;
  logic                     hist_empty, hist_full;
  logic [HW-1:0]            hist_top;
  logic [SW-1:0]            hist_cnt;
  logic [MAX_STONES*CW-1:0] hist_row, hist_col;

  assign hist_cnt = hist_top[HW-1 -: SW];
  assign hist_row = hist_top[2*MAX_STONES*CW-1 -: MAX_STONES*CW];
  assign hist_col = hist_top[MAX_STONES*CW-1:0];

  board_history_stack #(
    .DEPTH (HIST_DEPTH),
    .WIDTH (HW)
  ) u_history (
    .clock     (clock),
    .reset_h   (reset_h),
    .clear     (hist_clear),
    .push      (hist_push),
    .push_data ({cnt_q, colour_q, row_q, col_q}),
    .pop       (hist_pop),
    .top_data  (hist_top),
    .empty     (hist_empty),
    .full      (hist_full)
  );
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    colour_d   = colour_q;
    row_d      = row_q;
    col_d      = col_q;
    k_d        = k_q;
    board_d    = board_q;
    err_d      = err_q;
    move_cnt_d = move_cnt_q;
`ifdef BOARD_HISTORY_EN
    hist_push  = 1'b0;
    hist_pop   = 1'b0;
    hist_clear = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          board_d    = '0;
          move_cnt_d = '0;
          state_d    = ST_NOTIFY;
`ifdef BOARD_HISTORY_EN
          hist_clear = 1'b1;
        end else if (undo) begin
          if (hist_empty) begin
            err_d   = ERR_EMPTY_HIST;
            state_d = ST_REJECT;
          end else begin
            state_d = ST_UNDO;
          end
`endif
        end else if (mv_valid && mv_ready_q) begin
          cnt_d    = mv_count;
          colour_d = mv_colour;
          row_d    = mv_row;
          col_d    = mv_col;
          k_d      = '0;
          if (mv_count == '0 || int'(mv_count) > MAX_STONES) begin
            err_d   = ERR_COUNT;
            state_d = ST_REJECT;
          end else begin
            state_d = ST_CHECK;
          end
        end
      end

      ST_CHECK: begin
        if (!cur_in_bounds) begin
          err_d   = ERR_BOUNDS;
          state_d = ST_REJECT;
        end else if (cur_cell != CELL_EMPTY) begin
          err_d   = ERR_OCCUPIED;
          state_d = ST_REJECT;
        end else if (cur_dup) begin
          err_d   = ERR_DUPLICATE;
          state_d = ST_REJECT;
        end else if (int'(k_q) == int'(cnt_q) - 1) begin
          state_d = ST_COMMIT;
        end else begin
          k_d = k_q + SW'(1);
        end
      end

      ST_COMMIT: begin
        for (int s = 0; s < MAX_STONES; s++) begin
          if (s < int'(cnt_q)) begin
            board_d[2*cell_idx(int'(row_q[s*CW +: CW]), int'(col_q[s*CW +: CW]), BOARD_N) +: 2] =
              colour_q ? CELL_BLACK : CELL_WHITE;
          end
        end
        move_cnt_d = (move_cnt_q == 16'hFFFF) ? move_cnt_q : move_cnt_q + 16'd1;
        state_d    = ST_NOTIFY;
`ifdef BOARD_HISTORY_EN
        hist_push  = 1'b1;
`endif
      end

`ifdef BOARD_HISTORY_EN
      ST_UNDO: begin
        for (int s = 0; s < MAX_STONES; s++) begin
          if (s < int'(hist_cnt)) begin
            board_d[2*cell_idx(int'(hist_row[s*CW +: CW]), int'(hist_col[s*CW +: CW]), BOARD_N) +: 2] =
              CELL_EMPTY;
          end
        end
        move_cnt_d = (move_cnt_q == 16'd0) ? move_cnt_q : move_cnt_q - 16'd1;
        hist_pop   = 1'b1;
        state_d    = ST_NOTIFY;
      end
`endif

      ST_NOTIFY: state_d = ST_IDLE;
      ST_REJECT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    analyze_d  = (state_d == ST_NOTIFY);
    mv_err_d   = (state_d == ST_REJECT);
    mv_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset_h) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      colour_q   <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      k_q        <= '0;
      board_q    <= '0;
      err_q      <= ERR_NONE;
      move_cnt_q <= '0;
      analyze_q  <= 1'b1;
      mv_err_q   <= 1'b0;
      mv_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      colour_q   <= colour_d;
      row_q      <= row_d;
      col_q      <= col_d;
      k_q        <= k_d;
      board_q    <= board_d;
      err_q      <= err_d;
      move_cnt_q <= move_cnt_d;
      analyze_q  <= analyze_d;
      mv_err_q   <= mv_err_d;
      mv_ready_q <= mv_ready_d;
    end
  end

  assign board_out = board_q;
  assign analyze   = analyze_q;
  assign mv_err    = mv_err_q;
  assign err_code  = err_q;
  assign move_cnt  = move_cnt_q;
  assign mv_ready  = mv_ready_q;

endmodule

`default_nettype wire
